// File: rtl/axil_reg_slave.sv
// AXI4-Lite register-file responder; define AXIL_REG_SLAVE_ERR_EN for SLVERR on out-of-range words (else index wraps).
// Latency: B valid one edge after the later of the AW/W handshakes; R valid on the AR handshake edge.
// Backpressure: AW/W each stall while captured or while B is unacknowledged; AR stalls while R is held.
module axil_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3,
    parameter int DEPTH      = 4
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [RESP_WIDTH-1:0]   s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [RESP_WIDTH-1:0]   s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = ADDR_WIDTH - 2;
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  aw_full;
    logic                  w_full;
    logic [IW-1:0]         aw_idx;
    logic [DATA_WIDTH-1:0] w_data;
    logic [NB-1:0]         w_strb;
    logic [IW-1:0]         ar_idx;
    logic [MW-1:0]         aw_sel;
    logic [MW-1:0]         ar_sel;
    logic                  aw_hit;
    logic                  ar_hit;
    logic                  unused_ok;

    assign ar_idx = s_axi_araddr[ADDR_WIDTH-1:2];
    // Low index bits select the word; without the error option this is the wrap.
    assign aw_sel = aw_idx[MW-1:0];
    assign ar_sel = ar_idx[MW-1:0];

`ifdef AXIL_REG_SLAVE_ERR_EN
    assign aw_hit = 32'(aw_idx) < DEPTH;
    assign ar_hit = 32'(ar_idx) < DEPTH;
`else
    assign aw_hit = 1'b1;
    assign ar_hit = 1'b1;
`endif

    assign unused_ok = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wstrb[NB], aw_idx, ar_idx};

    assign s_axi_awready = s_axi_aresetn & ~aw_full & ~s_axi_bvalid;
    assign s_axi_wready  = s_axi_aresetn & ~w_full  & ~s_axi_bvalid;
    assign s_axi_arready = s_axi_aresetn & ~s_axi_rvalid;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            aw_idx       <= '0;
            w_data       <= '0;
            w_strb       <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            for (int d = 0; d < DEPTH; d++) begin
                mem[d] <= '0;
            end
        end else begin
            if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
            if (aw_full && w_full) begin
                aw_full      <= 1'b0;
                w_full       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= aw_hit ? RESP_OKAY : RESP_SLVERR;
                if (aw_hit) begin
                    for (int i = 0; i < NB; i++) begin
                        if (w_strb[i]) begin
                            mem[aw_sel][8*i +: 8] <= w_data[8*i +: 8];
                        end
                    end
                end
            end else begin
                if (s_axi_awvalid && s_axi_awready) begin
                    aw_full <= 1'b1;
                    aw_idx  <= s_axi_awaddr[ADDR_WIDTH-1:2];
                end
                if (s_axi_wvalid && s_axi_wready) begin
                    w_full <= 1'b1;
                    w_data <= s_axi_wdata;
                    w_strb <= s_axi_wstrb[NB-1:0];
                end
            end
        end
    end

    // Reads sample mem before this edge's commit lands, giving read-first ordering.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
        end else begin
            if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
            if (s_axi_arvalid && s_axi_arready) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= ar_hit ? mem[ar_sel] : '0;
                s_axi_rresp  <= ar_hit ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Randomized AXI4-Lite traffic against a word-array reference model; responses are queued at issue
// and popped by an independent monitor on each B/R handshake.
module tb_axil_reg_slave;

    logic        s_axi_aclk = 1'b0;
    logic        s_axi_aresetn;
    logic [7:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [4:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [2:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [7:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [2:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    axil_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3), .DEPTH(4)) dut (
        .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 s_axi_aclk = ~s_axi_aclk;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  resp;
    } rexp_t;

    logic [31:0] mdl [4];
    logic [2:0]  bq [$];
    rexp_t       rq [$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge s_axi_aclk);
        #1;
    endtask

    function automatic logic [2:0] mdl_write(input logic [7:0] addr, input logic [31:0] data,
                                             input logic [4:0] strb);
        int idx = int'(addr) / 4;
`ifdef AXIL_REG_SLAVE_ERR_EN
        if (idx >= 4) return 3'd2;
`else
        idx = idx % 4;
`endif
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
        end
        return 3'd0;
    endfunction

    function automatic rexp_t mdl_read(input logic [7:0] addr);
        rexp_t e;
        int idx = int'(addr) / 4;
`ifdef AXIL_REG_SLAVE_ERR_EN
        if (idx >= 4) begin
            e.data = 32'd0;
            e.resp = 3'd2;
            return e;
        end
`else
        idx = idx % 4;
`endif
        e.data = mdl[idx];
        e.resp = 3'd0;
        return e;
    endfunction

    function automatic logic [7:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 8'($urandom);
        return 8'($urandom_range(0, 3) << 2) | 8'($urandom_range(0, 3));
    endfunction

    // Monitor: every B/R handshake pops and checks the oldest expected response.
    initial begin
        rexp_t e;
        logic [2:0] eb;
        forever begin
            @(negedge s_axi_aclk);
            if (s_axi_aresetn === 1'b1) begin
                if (s_axi_bvalid && s_axi_bready) begin
                    if (bq.size() == 0) chk("b_unexpected", {31'd0, s_axi_bvalid}, 32'd0);
                    else begin
                        eb = bq.pop_front();
                        chk("bresp", {29'd0, s_axi_bresp}, {29'd0, eb});
                    end
                end
                if (s_axi_rvalid && s_axi_rready) begin
                    if (rq.size() == 0) chk("r_unexpected", {31'd0, s_axi_rvalid}, 32'd0);
                    else begin
                        e = rq.pop_front();
                        chk("rdata", s_axi_rdata, e.data);
                        chk("rresp", {29'd0, s_axi_rresp}, {29'd0, e.resp});
                    end
                end
            end
        end
    end

    task automatic write_op(input logic [7:0] addr, input logic [31:0] data, input logic [4:0] strb,
                            input int aw_dly, input int w_dly, input int bd);
        logic [2:0] resp;
        int n;
        resp = mdl_write(addr, data, strb);
        bq.push_back(resp);
        s_axi_bready = (bd == 0);
        fork
            begin
                int k;
                repeat (aw_dly) begin
                    tick();
                    if (w_dly == 0) begin
                        chk("wfirst_awready", {31'd0, s_axi_awready}, 32'd1);
                        chk("wfirst_wready", {31'd0, s_axi_wready}, 32'd0);
                    end
                end
                s_axi_awaddr = addr;
                s_axi_awvalid = 1'b1;
                k = 0;
                @(negedge s_axi_aclk);
                while (!s_axi_awready && k < 100) begin @(negedge s_axi_aclk); k++; end
                chk("aw_handshake", {31'd0, s_axi_awready}, 32'd1);
                tick();
                s_axi_awvalid = 1'b0;
            end
            begin
                int k;
                repeat (w_dly) tick();
                s_axi_wdata = data;
                s_axi_wstrb = strb;
                s_axi_wvalid = 1'b1;
                k = 0;
                @(negedge s_axi_aclk);
                while (!s_axi_wready && k < 100) begin @(negedge s_axi_aclk); k++; end
                chk("w_handshake", {31'd0, s_axi_wready}, 32'd1);
                tick();
                s_axi_wvalid = 1'b0;
            end
        join
        chk("b_not_yet", {31'd0, s_axi_bvalid}, 32'd0);
        tick();
        chk("b_latency", {31'd0, s_axi_bvalid}, 32'd1);
        for (int i = 0; i < bd; i++) begin
            chk("bstall_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
            chk("bstall_bresp", {29'd0, s_axi_bresp}, {29'd0, resp});
            chk("bstall_awready", {31'd0, s_axi_awready}, 32'd0);
            chk("bstall_wready", {31'd0, s_axi_wready}, 32'd0);
            tick();
        end
        s_axi_bready = 1'b1;
        n = 0;
        @(negedge s_axi_aclk);
        while (!s_axi_bvalid && n < 100) begin @(negedge s_axi_aclk); n++; end
        chk("b_handshake", {31'd0, s_axi_bvalid}, 32'd1);
        tick();
        s_axi_bready = 1'b0;
        chk("post_b_awready", {31'd0, s_axi_awready}, 32'd1);
        chk("post_b_wready", {31'd0, s_axi_wready}, 32'd1);
    endtask

    task automatic read_op(input logic [7:0] addr, input int rd);
        rexp_t e;
        int n;
        e = mdl_read(addr);
        rq.push_back(e);
        s_axi_rready = (rd == 0);
        s_axi_araddr = addr;
        s_axi_arvalid = 1'b1;
        n = 0;
        @(negedge s_axi_aclk);
        while (!s_axi_arready && n < 100) begin @(negedge s_axi_aclk); n++; end
        chk("ar_handshake", {31'd0, s_axi_arready}, 32'd1);
        tick();
        s_axi_arvalid = 1'b0;
        chk("r_latency", {31'd0, s_axi_rvalid}, 32'd1);
        chk("r_arready_low", {31'd0, s_axi_arready}, 32'd0);
        for (int i = 0; i < rd; i++) begin
            tick();
            chk("rstall_rvalid", {31'd0, s_axi_rvalid}, 32'd1);
            chk("rstall_rdata", s_axi_rdata, e.data);
        end
        s_axi_rready = 1'b1;
        n = 0;
        @(negedge s_axi_aclk);
        while (!s_axi_rvalid && n < 100) begin @(negedge s_axi_aclk); n++; end
        chk("r_handshake", {31'd0, s_axi_rvalid}, 32'd1);
        tick();
        s_axi_rready = 1'b0;
        chk("post_r_arready", {31'd0, s_axi_arready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rexp_t e;
        logic [2:0] resp;
        int n;
        for (int i = 0; i < 4; i++) mdl[i] = 32'd0;
        s_axi_aresetn = 1'b0;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        repeat (3) @(negedge s_axi_aclk);
        chk("rst_awready", {31'd0, s_axi_awready}, 32'd0);
        chk("rst_arready", {31'd0, s_axi_arready}, 32'd0);
        @(posedge s_axi_aclk);
        #1 s_axi_aresetn = 1'b1;
        @(negedge s_axi_aclk);
        chk("idle_awready", {31'd0, s_axi_awready}, 32'd1);
        chk("idle_wready", {31'd0, s_axi_wready}, 32'd1);
        chk("idle_arready", {31'd0, s_axi_arready}, 32'd1);
        chk("idle_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
        chk("idle_rvalid", {31'd0, s_axi_rvalid}, 32'd0);
        chk("idle_rdata", s_axi_rdata, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) read_op(8'(i * 4), 0);

        write_op(8'h04, 32'h12345678, 5'h0F, 0, 0, 0);
        read_op(8'h04, 0);
        write_op(8'h04, 32'hAABBCCDD, 5'h05, 2, 0, 0);
        read_op(8'h04, 0);
        write_op(8'h08, 32'h55AA33CC, 5'h1F, 0, 1, 5);
        write_op(8'h08, 32'hFFFFFFFF, 5'h10, 0, 0, 0);
        read_op(8'h0B, 2);
        write_op(8'h40, 32'hCAFEF00D, 5'h0F, 0, 0, 1);
        read_op(8'h40, 0);
        read_op(8'h00, 0);

        // Read and commit to the same word on one edge: read must see the old value.
        rq.push_back(mdl_read(8'h04));
        bq.push_back(mdl_write(8'h04, 32'h0BADBEEF, 5'h0F));
        s_axi_awaddr = 8'h04; s_axi_wdata = 32'h0BADBEEF; s_axi_wstrb = 5'h0F;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_araddr = 8'h04; s_axi_arvalid = 1'b1; s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        chk("rf_rvalid", {31'd0, s_axi_rvalid}, 32'd1);
        chk("rf_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
        tick();
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        read_op(8'h04, 0);

        // Reset with an AW captured and R held: both must be discarded.
        s_axi_awaddr = 8'h0C; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_araddr = 8'h04; s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        chk("pre_rst_rvalid", {31'd0, s_axi_rvalid}, 32'd1);
        #2 s_axi_aresetn = 1'b0;
        #1;
        chk("mid_rst_rvalid", {31'd0, s_axi_rvalid}, 32'd0);
        chk("mid_rst_awready", {31'd0, s_axi_awready}, 32'd0);
        chk("mid_rst_wready", {31'd0, s_axi_wready}, 32'd0);
        for (int i = 0; i < 4; i++) mdl[i] = 32'd0;
        @(posedge s_axi_aclk);
        #3 s_axi_aresetn = 1'b1;
        @(negedge s_axi_aclk);
        chk("rel_rvalid", {31'd0, s_axi_rvalid}, 32'd0);
        chk("rel_rdata", s_axi_rdata, 32'd0);
        chk("rel_awready", {31'd0, s_axi_awready}, 32'd1);
        chk("rel_arready", {31'd0, s_axi_arready}, 32'd1);
        tick();
        s_axi_wdata = 32'h600DF00D; s_axi_wstrb = 5'h0F; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        tick();
        s_axi_wvalid = 1'b0;
        repeat (4) begin
            tick();
            chk("lone_w_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
            chk("lone_w_awready", {31'd0, s_axi_awready}, 32'd1);
        end
        resp = mdl_write(8'h0C, 32'h600DF00D, 5'h0F);
        bq.push_back(resp);
        s_axi_awaddr = 8'h0C; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        tick();
        chk("late_aw_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
        tick();
        s_axi_bready = 1'b0;
        read_op(8'h0C, 0);
        read_op(8'h04, 0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 1)
                write_op(rand_addr(), $urandom, 5'($urandom), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            else
                read_op(rand_addr(), $urandom_range(0, 3));
        end

        repeat (3) tick();
        n = bq.size();
        chk("bq_drained", 32'(n), 32'd0);
        n = rq.size();
        chk("rq_drained", 32'(n), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
